motor_pwm_ctrl: RTL and testbench

MOTOR_PWM_CTRL -- requirements
Module: motor_pwm_ctrl

---
 rtl/motor_pwm_pkg.sv | 31 +++
 rtl/motor_pwm_channel.sv | 98 +++++++++
 rtl/motor_pwm_ctrl.sv | 56 +++++
 tb/tb_motor_pwm_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pwm_pkg.sv
// Shared types and speed-to-duty mapping for the multi-channel motor PWM controller.
package motor_pwm_pkg;

  localparam int unsigned SPEED_W = 3;
  localparam int unsigned N_CODES = 8;

  typedef enum logic [SPEED_W-1:0] {
    SPD_STOP = 3'd0,
    SPD_65   = 3'd1,
    SPD_75   = 3'd2,
    SPD_85   = 3'd3,
    SPD_95   = 3'd4,
    SPD_RSV5 = 3'd5,
    SPD_RSV6 = 3'd6,
    SPD_RSV7 = 3'd7
  } speed_code_t;

  // Percent of period per speed code; reserved codes stop the motor.
  localparam logic [6:0] SPEED_PCT [N_CODES] = '{
    7'd0, 7'd65, 7'd75, 7'd85, 7'd95, 7'd0, 7'd0, 7'd0
  };

  // Floored PERIOD*pct/100; only ever called with constant arguments.
  function automatic logic [31:0] duty_from_code(input speed_code_t code,
                                                 input longint unsigned period);
    longint unsigned prod;
    prod = period * 64'(SPEED_PCT[code]);
    return 32'(prod / 64'd100);
  endfunction

endpackage

// File: rtl/motor_pwm_channel.sv
// One motor channel: rate-limited duty ramp, safe direction reversal, brake and PWM compare.
module motor_pwm_channel
  import motor_pwm_pkg::*;
#(
  parameter int unsigned CNT_W     = 21,
  parameter int unsigned PERIOD    = 1_000_000,
  parameter int unsigned RAMP_STEP = 50_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic             i_pend,
  input  speed_code_t      i_code,
  input  logic             i_dir_req,
  input  logic             i_brake,
  output logic             o_pwm,
  output logic             o_dir,
  output logic             o_at_speed
);

  localparam int unsigned       EXT_W = CNT_W + 1;
  localparam logic [EXT_W-1:0]  STEP  = EXT_W'(RAMP_STEP);

  logic [CNT_W-1:0] w_tgt_tbl [N_CODES];

  logic [CNT_W-1:0] r_duty;
  logic [CNT_W-1:0] r_tgt;
  logic             r_dir;
  logic             r_pwm;
  logic             r_at;

  logic [EXT_W-1:0] w_duty_ext;
  logic [EXT_W-1:0] w_tgt_ext;
  logic [EXT_W-1:0] w_eff_tgt;
  logic [EXT_W-1:0] w_ramp_up;
  logic [EXT_W-1:0] w_ramp_dn;
  logic [CNT_W-1:0] w_duty_nxt;
  logic [CNT_W-1:0] w_tgt_nxt;
  logic             w_dir_nxt;
  logic             w_pwm_nxt;
  logic             w_at_nxt;

  // Constant target table, one entry per speed code.
  for (genvar k = 0; k < int'(N_CODES); k++) begin : g_tgt
    assign w_tgt_tbl[k] = CNT_W'(duty_from_code(speed_code_t'(3'(k)), 64'(PERIOD)));
  end

  // Duty only moves at period end so no pulse is cut short; brake overrides at once.
  always_comb begin
    w_duty_ext = {1'b0, r_duty};
    w_tgt_ext  = {1'b0, w_tgt_tbl[i_code]};
    w_eff_tgt  = (i_dir_req != r_dir) ? '0 : w_tgt_ext;
    w_ramp_up  = w_duty_ext + STEP;
    w_ramp_dn  = (w_duty_ext > STEP) ? (w_duty_ext - STEP) : '0;
    w_duty_nxt = r_duty;
    w_tgt_nxt  = r_tgt;
    w_dir_nxt  = r_dir;
    w_pwm_nxt  = (i_cnt < r_duty);
    w_at_nxt   = (r_duty == r_tgt) && (r_dir == i_dir_req) && !i_brake;

    if (i_pend) begin
      w_tgt_nxt = w_tgt_tbl[i_code];
    end

    if (i_brake) begin
      w_duty_nxt = '0;
    end else if (i_pend) begin
      if ((i_dir_req != r_dir) && (r_duty == '0)) begin
        w_dir_nxt = i_dir_req;
      end else if (w_duty_ext < w_eff_tgt) begin
        w_duty_nxt = CNT_W'((w_ramp_up < w_eff_tgt) ? w_ramp_up : w_eff_tgt);
      end else if (w_duty_ext > w_eff_tgt) begin
        w_duty_nxt = CNT_W'((w_ramp_dn > w_eff_tgt) ? w_ramp_dn : w_eff_tgt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_duty <= '0;
      r_tgt  <= '0;
      r_dir  <= 1'b0;
      r_pwm  <= 1'b0;
      r_at   <= 1'b0;
    end else begin
      r_duty <= w_duty_nxt;
      r_tgt  <= w_tgt_nxt;
      r_dir  <= w_dir_nxt;
      r_pwm  <= w_pwm_nxt;
      r_at   <= w_at_nxt;
    end
  end

  assign o_pwm      = r_pwm;
  assign o_dir      = r_dir;
  assign o_at_speed = r_at;

endmodule

// File: rtl/motor_pwm_ctrl.sv
// N-channel motor PWM controller: one shared period counter feeding independent channels.
module motor_pwm_ctrl
  import motor_pwm_pkg::*;
#(
  parameter int unsigned N_CH      = 2,
  parameter int unsigned CNT_W     = 21,
  parameter int unsigned PERIOD    = 1_000_000,
  parameter int unsigned RAMP_STEP = 50_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SPEED_W*N_CH-1:0] speed_code,
  input  logic [N_CH-1:0]         dir_req,
  input  logic [N_CH-1:0]         brake,
  output logic [N_CH-1:0]         pwm,
  output logic [N_CH-1:0]         dir,
  output logic [N_CH-1:0]         at_speed
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_pend;

  assign w_pend = (r_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_pend) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    motor_pwm_channel #(
      .CNT_W     (CNT_W),
      .PERIOD    (PERIOD),
      .RAMP_STEP (RAMP_STEP)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .i_cnt      (r_cnt),
      .i_pend     (w_pend),
      .i_code     (speed_code_t'(speed_code[SPEED_W*i +: SPEED_W])),
      .i_dir_req  (dir_req[i]),
      .i_brake    (brake[i]),
      .o_pwm      (pwm[i]),
      .o_dir      (dir[i]),
      .o_at_speed (at_speed[i])
    );
  end

endmodule

// File: tb/tb_motor_pwm_ctrl.sv
// Bench for motor_pwm_ctrl with PERIOD=100, RAMP_STEP=10: duty is measured as pwm-high count per period.
module tb_motor_pwm_ctrl;

  localparam int N_CH      = 2;
  localparam int CNT_W     = 7;
  localparam int PERIOD    = 100;
  localparam int RAMP_STEP = 10;

  logic                clk;
  logic                reset;
  logic [3*N_CH-1:0]   speed_code;
  logic [N_CH-1:0]     dir_req;
  logic [N_CH-1:0]     brake;
  logic [N_CH-1:0]     pwm;
  logic [N_CH-1:0]     dir;
  logic [N_CH-1:0]     at_speed;

  typedef struct {
    logic [2:0] c0;
    logic       dr0;
    int         d0;
    logic       dir0;
    logic       at0;
    int         d1;
    logic       dir1;
    logic       at1;
  } vec_t;

  typedef struct {
    int   d0;
    logic dir0;
    logic at0;
    int   d1;
    logic dir1;
    logic at1;
  } exp_t;

  vec_t tbl [$];
  exp_t sb  [$];

  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   n_glitch = 0;
  bit   mon_en   = 1'b0;
  logic [N_CH-1:0] prev_dir = '0;
  logic [N_CH-1:0] prev_pwm = '0;

  motor_pwm_ctrl #(
    .N_CH      (N_CH),
    .CNT_W     (CNT_W),
    .PERIOD    (PERIOD),
    .RAMP_STEP (RAMP_STEP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .speed_code (speed_code),
    .dir_req    (dir_req),
    .brake      (brake),
    .pwm        (pwm),
    .dir        (dir),
    .at_speed   (at_speed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Direction must never change while its pwm is (or just was) driven.
  always @(negedge clk) begin
    for (int c = 0; c < N_CH; c++) begin
      if (mon_en && (dir[c] != prev_dir[c]) && (pwm[c] || prev_pwm[c])) n_glitch++;
    end
    prev_dir <= dir;
    prev_pwm <= pwm;
  end

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Channel 1 holds code 2 / forward: first period end flips dir, then ramps to 75.
  function automatic void add(input logic [2:0] c, input logic dr, input int d,
                              input logic dr_o, input logic at);
    vec_t v;
    int   j;
    j      = tbl.size();
    v.c0   = c;
    v.dr0  = dr;
    v.d0   = d;
    v.dir0 = dr_o;
    v.at0  = at;
    v.d1   = (j == 0) ? 0 : ((10 * j < 75) ? 10 * j : 75);
    v.dir1 = 1'b1;
    v.at1  = (j >= 8);
    tbl.push_back(v);
  endfunction

  task automatic count_win(output int h0, output int h1);
    h0 = 0;
    h1 = 0;
    for (int k = 0; k < PERIOD; k++) begin
      h0 += int'(pwm[0]);
      h1 += int'(pwm[1]);
      @(negedge clk);
    end
  endtask

  // Starts at the interval where counter==1; drives the next vector and measures this period.
  task automatic table_window(input int j, input bit drive, input vec_t v);
    exp_t            e;
    exp_t            x;
    int              h0;
    int              h1;
    logic [N_CH-1:0] dir_s;
    logic [N_CH-1:0] at_s;
    dir_s = dir;
    at_s  = at_speed;
    if (drive) begin
      speed_code = {3'd2, v.c0};
      dir_req    = {1'b1, v.dr0};
      x.d0 = v.d0;  x.dir0 = v.dir0;  x.at0 = v.at0;
      x.d1 = v.d1;  x.dir1 = v.dir1;  x.at1 = v.at1;
      sb.push_back(x);
    end
    count_win(h0, h1);
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL w%0d_scoreboard: got empty queue expected an entry", j);
    end else begin
      e = sb.pop_front();
      chk($sformatf("w%0d_duty0", j), h0, e.d0);
      chk($sformatf("w%0d_dir0", j), int'(dir_s[0]), int'(e.dir0));
      chk($sformatf("w%0d_at0", j), int'(at_s[0]), int'(e.at0));
      chk($sformatf("w%0d_duty1", j), h1, e.d1);
      chk($sformatf("w%0d_dir1", j), int'(dir_s[1]), int'(e.dir1));
      chk($sformatf("w%0d_at1", j), int'(at_s[1]), int'(e.at1));
    end
  endtask

  initial begin
    exp_t e0;
    int   h0;
    int   h1;
    int   n;

    // Ramp up to 65, hold, step to 95.
    for (int k = 1; k <= 7; k++) add(3'd1, 1'b0, (10 * k < 65) ? 10 * k : 65, 1'b0, k == 7);
    add(3'd1, 1'b0, 65, 1'b0, 1'b1);
    add(3'd4, 1'b0, 75, 1'b0, 1'b0);
    add(3'd4, 1'b0, 85, 1'b0, 1'b0);
    add(3'd4, 1'b0, 95, 1'b0, 1'b1);
    // Stop code ramps down to 0; reserved codes also mean stop.
    for (int k = 1; k <= 10; k++) add(3'd0, 1'b0, (95 - 10 * k > 0) ? 95 - 10 * k : 0, 1'b0, k == 10);
    add(3'd5, 1'b0, 0, 1'b0, 1'b1);
    add(3'd6, 1'b0, 0, 1'b0, 1'b1);
    add(3'd7, 1'b0, 0, 1'b0, 1'b1);
    add(3'd1, 1'b0, 10, 1'b0, 1'b0);
    add(3'd7, 1'b0, 0, 1'b0, 1'b1);
    // Reverse to forward at rest, ramp to 75, then reverse back.
    add(3'd2, 1'b1, 0, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) add(3'd2, 1'b1, (10 * k < 75) ? 10 * k : 75, 1'b1, k == 8);
    for (int k = 1; k <= 8; k++) add(3'd2, 1'b0, (75 - 10 * k > 0) ? 75 - 10 * k : 0, 1'b1, 1'b0);
    add(3'd2, 1'b0, 0, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) add(3'd2, 1'b0, (10 * k < 75) ? 10 * k : 75, 1'b0, k == 8);
    add(3'd3, 1'b0, 85, 1'b0, 1'b1);
    add(3'd3, 1'b0, 85, 1'b0, 1'b1);

    reset      = 1'b1;
    speed_code = '0;
    dir_req    = '0;
    brake      = '0;
    repeat (3) @(negedge clk);
    chk("reset_pwm", int'(pwm), 0);
    chk("reset_dir", int'(dir), 0);
    chk("reset_at_speed", int'(at_speed), 0);
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    e0.d0 = 0;  e0.dir0 = 1'b0;  e0.at0 = 1'b1;
    e0.d1 = 0;  e0.dir1 = 1'b0;  e0.at1 = 1'b1;
    sb.push_back(e0);
    n = tbl.size();
    for (int j = 0; j <= n; j++) table_window(j, j < n, tbl[(j < n) ? j : n - 1]);

    // Brake mid-pulse at duty 85, hold across a period end, release mid-period.
    repeat (39) @(negedge clk);
    chk("brk_pre_pwm0", int'(pwm[0]), 1);
    brake[0] = 1'b1;
    @(negedge clk);
    chk("brk_at0", int'(at_speed[0]), 0);
    @(negedge clk);
    chk("brk_pwm0_off", int'(pwm[0]), 0);
    chk("brk_dir0_held", int'(dir[0]), 0);
    chk("brk_pwm1_live", int'(pwm[1]), 1);
    repeat (59) @(negedge clk);
    h0 = 0;
    h1 = 0;
    for (int k = 0; k < PERIOD; k++) begin
      h0 += int'(pwm[0]);
      h1 += int'(pwm[1]);
      if (k == 50) brake[0] = 1'b0;
      @(negedge clk);
    end
    chk("brk_win_duty0", h0, 0);
    chk("brk_win_duty1", h1, 75);
    chk("brk_win_dir0", int'(dir[0]), 0);
    count_win(h0, h1);
    chk("brk_rel_duty0", h0, 10);
    chk("brk_rel_duty1", h1, 75);

    // Reset at counter==37 while ch0 ramps.
    repeat (36) @(negedge clk);
    mon_en = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    chk("mid_rst_pwm", int'(pwm), 0);
    chk("mid_rst_dir", int'(dir), 0);
    chk("mid_rst_at_speed", int'(at_speed), 0);
    reset = 1'b0;
    speed_code[2:0] = 3'd1;
    @(negedge clk);
    mon_en = 1'b1;
    count_win(h0, h1);
    chk("post_rst_w0_duty0", h0, 0);
    chk("post_rst_w0_duty1", h1, 0);
    chk("post_rst_first_pulse", int'(pwm[0]), 1);
    chk("post_rst_dir1_flip", int'(dir[1]), 1);
    count_win(h0, h1);
    chk("post_rst_w1_duty0", h0, 10);
    chk("post_rst_w1_duty1", h1, 0);
    count_win(h0, h1);
    chk("post_rst_w2_duty0", h0, 20);
    chk("post_rst_w2_duty1", h1, 10);

    chk("dir_change_while_driven", n_glitch, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
